mul_rr_arbiter: RTL and testbench

//  Round-robin arbiter/sequencer sharing one 32x32 signed Booth multiplier (op_start/op_clear/op_done

---
 rtl/mul_rr_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mul_rr_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_rr_arbiter.sv
// Round-robin sequencer that shares one 32x32 signed multiplier among NUM_REQ requesters.
// Each grant runs START -> WAIT -> CLEAR -> RESP; a watchdog ends a hung WAIT with err.
module mul_rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [32*NUM_REQ-1:0]     multiplicand_in,
  input  logic [32*NUM_REQ-1:0]     multiplier_in,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        done,
  output logic                      err,
  output logic [63:0]               result,
  output logic                      busy,
  output logic                      mul_op_start,
  output logic                      mul_op_clear,
  output logic [31:0]               mul_multiplicand,
  output logic [31:0]               mul_multiplier,
  input  logic [63:0]               mul_result,
  input  logic                      mul_op_done
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned RES_W  = 64;
  localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_CLEAR = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]  a_q, a_d;
  logic [DATA_W-1:0]  x_q, x_d;
  logic [RES_W-1:0]   result_q, result_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_flag_q, err_flag_d;

  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;

  logic [NUM_REQ-1:0] grant_d, done_d;
  logic               err_d, busy_d, start_d, clear_d;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
    return NUM_REQ'(1) << i;
  endfunction

  // First requester at or after ptr, wrapping around.
  always_comb begin
    int unsigned cand;
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = 32'(ptr_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!pick_valid && req[IDX_W'(cand)]) begin
        pick_valid = 1'b1;
        pick_idx   = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    idx_d      = idx_q;
    a_d        = a_q;
    x_d        = x_q;
    result_d   = result_q;
    cnt_d      = cnt_q;
    err_flag_d = err_flag_q;

    unique case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          idx_d      = pick_idx;
          a_d        = DATA_W'(multiplicand_in >> (DATA_W * 32'(pick_idx)));
          x_d        = DATA_W'(multiplier_in >> (DATA_W * 32'(pick_idx)));
          cnt_d      = '0;
          err_flag_d = 1'b0;
          state_d    = S_START;
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // A completion in the same cycle as the watchdog expiry is still a success.
        if (mul_op_done) begin
          result_d = mul_result;
          state_d  = S_CLEAR;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_flag_d = 1'b1;
          state_d    = S_CLEAR;
        end
      end
      S_CLEAR: state_d = S_RESP;
      S_RESP: begin
        ptr_d   = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they register in step with it.
    grant_d = '0;
    done_d  = '0;
    err_d   = 1'b0;
    busy_d  = (state_d != S_IDLE);
    start_d = (state_d == S_START);
    clear_d = (state_d == S_CLEAR);
    if (state_d != S_IDLE) grant_d = onehot(idx_d);
    if (state_d == S_RESP) begin
      done_d = onehot(idx_d);
      err_d  = err_flag_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      idx_q        <= '0;
      a_q          <= '0;
      x_q          <= '0;
      result_q     <= '0;
      cnt_q        <= '0;
      err_flag_q   <= 1'b0;
      grant        <= '0;
      done         <= '0;
      err          <= 1'b0;
      busy         <= 1'b0;
      mul_op_start <= 1'b0;
      mul_op_clear <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      idx_q        <= idx_d;
      a_q          <= a_d;
      x_q          <= x_d;
      result_q     <= result_d;
      cnt_q        <= cnt_d;
      err_flag_q   <= err_flag_d;
      grant        <= grant_d;
      done         <= done_d;
      err          <= err_d;
      busy         <= busy_d;
      mul_op_start <= start_d;
      mul_op_clear <= clear_d;
    end
  end

  assign result           = result_q;
  assign mul_multiplicand = a_q;
  assign mul_multiplier   = x_q;

endmodule

// File: tb/tb_mul_rr_arbiter.sv
// Directed bench for mul_rr_arbiter with a behavioural multiplier stub (fixed latency,
// completion can be suppressed to exercise the watchdog).
module tb_mul_rr_arbiter;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned TIMEOUT = 64;
  localparam int          LAT     = 3;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic [NUM_REQ-1:0]     req;
  logic [32*NUM_REQ-1:0]  multiplicand_in;
  logic [32*NUM_REQ-1:0]  multiplier_in;
  logic [NUM_REQ-1:0]     grant;
  logic [NUM_REQ-1:0]     done;
  logic                   err;
  logic [63:0]            result;
  logic                   busy;
  logic                   mul_op_start;
  logic                   mul_op_clear;
  logic [31:0]            mul_multiplicand;
  logic [31:0]            mul_multiplier;
  logic [63:0]            mul_result;
  logic                   mul_op_done;

  int n_checks = 0;
  int n_errors = 0;
  int n_start  = 0;
  int n_clear  = 0;
  int n_done0  = 0;
  int n_done1  = 0;

  logic              stub_en;
  logic              m_busy;
  int                m_cnt;
  logic signed [63:0] ea, eb;

  mul_rr_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .req              (req),
    .multiplicand_in  (multiplicand_in),
    .multiplier_in    (multiplier_in),
    .grant            (grant),
    .done             (done),
    .err              (err),
    .result           (result),
    .busy             (busy),
    .mul_op_start     (mul_op_start),
    .mul_op_clear     (mul_op_clear),
    .mul_multiplicand (mul_multiplicand),
    .mul_multiplier   (mul_multiplier),
    .mul_result       (mul_result),
    .mul_op_done      (mul_op_done)
  );

  always #5 clk = ~clk;

  // Multiplier stand-in: op_done rises LAT+1 cycles after op_start, held until op_clear.
  assign ea = {{32{mul_multiplicand[31]}}, mul_multiplicand};
  assign eb = {{32{mul_multiplier[31]}}, mul_multiplier};
  always @(posedge clk) begin
    if (!reset_n) begin
      mul_op_done <= 1'b0;
      mul_result  <= '0;
      m_busy      <= 1'b0;
      m_cnt       <= 0;
    end else if (mul_op_clear) begin
      mul_op_done <= 1'b0;
      m_busy      <= 1'b0;
    end else if (mul_op_start) begin
      m_busy <= 1'b1;
      m_cnt  <= LAT;
    end else if (m_busy) begin
      if (m_cnt == 0) begin
        m_busy <= 1'b0;
        if (stub_en) begin
          mul_op_done <= 1'b1;
          mul_result  <= ea * eb;
        end else begin
          mul_result  <= 64'hDEAD_BEEF_0BAD_F00D;
        end
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (mul_op_start) n_start++;
    if (mul_op_clear) n_clear++;
    if (done[0]) n_done0++;
    if (done[1]) n_done1++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [NUM_REQ-1:0] oh(input int i);
    logic [NUM_REQ-1:0] v;
    v = NUM_REQ'(1) << i;
    return v;
  endfunction

  task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] x);
    multiplicand_in[32*i +: 32] = a;
    multiplier_in[32*i +: 32]   = x;
  endtask

  // Advance on falling edges until a done pulse is visible; cyc = edges advanced.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done == '0 && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    if (done == '0) check("done_wait_expired", 64'd0, 64'd1);
  endtask

  task automatic serve_one(input string tag, input int i, input logic [31:0] a,
                           input logic [31:0] x, input logic [63:0] exp_res);
    int cyc;
    int s0, c0;
    set_ops(i, a, x);
    s0 = n_start;
    c0 = n_clear;
    req[i] = 1'b1;
    @(negedge clk);
    check({tag, "_grant"}, 64'(grant), 64'(oh(i)));
    check({tag, "_start"}, 64'(mul_op_start), 64'd1);
    wait_done(cyc);
    check({tag, "_latency"}, 64'(cyc), 64'd7);
    check({tag, "_done"}, 64'(done), 64'(oh(i)));
    check({tag, "_result"}, result, exp_res);
    check({tag, "_err"}, 64'(err), 64'd0);
    req[i] = 1'b0;
    @(negedge clk);
    check({tag, "_nstart"}, 64'(n_start - s0), 64'd1);
    check({tag, "_nclear"}, 64'(n_clear - c0), 64'd1);
    check({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"}, 64'(grant), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_err"}, 64'(err), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_result"}, result, 64'd0);
    check({tag, "_start"}, 64'(mul_op_start), 64'd0);
    check({tag, "_clear"}, 64'(mul_op_clear), 64'd0);
    check({tag, "_opa"}, 64'(mul_multiplicand), 64'd0);
    check({tag, "_opx"}, 64'(mul_multiplier), 64'd0);
  endtask

  initial begin
    int cyc;
    int s0, c0, d0;
    logic [NUM_REQ-1:0] exp_oh;
    reset_n         = 1'b0;
    req             = '0;
    multiplicand_in = '0;
    multiplier_in   = '0;
    stub_en         = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // T1 / T2: single requesters, signed operands
    serve_one("t1", 0, 32'd3, 32'd5, 64'd15);
    serve_one("t2_neg", 1, -32'sd7, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6);
    serve_one("t2_min", 0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);

    // T3: both held from reset, grants alternate 0,1,0,1
    reset_n = 1'b0;
    set_ops(0, 32'd2, 32'd3);
    set_ops(1, 32'd4, 32'd5);
    req = 2'b11;
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_done(cyc);
      exp_oh = oh(k % 2);
      check($sformatf("t3_done%0d", k), 64'(done), 64'(exp_oh));
      check($sformatf("t3_result%0d", k), result, (k % 2 == 1) ? 64'd20 : 64'd6);
      check($sformatf("t3_err%0d", k), 64'(err), 64'd0);
      if (k == 3) req = '0;
      @(negedge clk);
    end

    // T4: multiplier never completes -> watchdog
    stub_en = 1'b0;
    set_ops(0, 32'd11, 32'd13);
    c0 = n_clear;
    req = 2'b01;
    @(negedge clk);
    check("t4_start", 64'(mul_op_start), 64'd1);
    wait_done(cyc);
    check("t4_latency", 64'(cyc), 64'(TIMEOUT + 2));
    check("t4_done", 64'(done), 64'd1);
    check("t4_err", 64'(err), 64'd1);
    check("t4_result_kept", result, 64'd20);
    check("t4_nclear", 64'(n_clear - c0), 64'd1);
    req = '0;
    @(negedge clk);
    stub_en = 1'b1;

    // T5: reset mid-WAIT, then pointer must be back at requester 0
    stub_en = 1'b0;
    set_ops(0, 32'd1, 32'd1);
    req = 2'b01;
    repeat (5) @(negedge clk);
    check("t5_busy_wait", 64'(busy), 64'd1);
    reset_n = 1'b0;
    req = '0;
    @(negedge clk);
    check_all_zero("t5_reset");
    reset_n = 1'b1;
    stub_en = 1'b1;
    set_ops(0, 32'd9, 32'd9);
    set_ops(1, 32'd4, 32'd4);
    req = 2'b11;
    wait_done(cyc);
    check("t5_done0", 64'(done), 64'd1);
    check("t5_result0", result, 64'd81);
    check("t5_err0", 64'(err), 64'd0);
    req = 2'b10;
    @(negedge clk);
    wait_done(cyc);
    check("t5_done1", 64'(done), 64'd2);
    check("t5_result1", result, 64'd16);
    req = '0;
    @(negedge clk);

    // T6: req1 raised in RESP, req0 lingers one cycle -> req1 next, no re-service of req0
    set_ops(0, 32'd2, 32'd7);
    set_ops(1, 32'd3, 32'd3);
    d0 = n_done0;
    req = 2'b01;
    wait_done(cyc);
    check("t6_done0", 64'(done), 64'd1);
    check("t6_result0", result, 64'd14);
    req[1] = 1'b1;
    @(negedge clk);
    check("t6_idle_busy", 64'(busy), 64'd0);
    check("t6_idle_grant", 64'(grant), 64'd0);
    req[0] = 1'b0;
    s0 = n_start;
    @(negedge clk);
    check("t6_grant1", 64'(grant), 64'd2);
    check("t6_start1", 64'(mul_op_start), 64'd1);
    wait_done(cyc);
    check("t6_latency1", 64'(cyc), 64'd7);
    check("t6_done1", 64'(done), 64'd2);
    check("t6_result1", result, 64'd9);
    req = '0;
    repeat (20) @(negedge clk);
    check("t6_req0_once", 64'(n_done0 - d0), 64'd1);
    check("t6_nstart", 64'(n_start - s0), 64'd1);
    check("t6_quiet", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
